// File: rtl/lane_shift_register.sv
// Lane occupancy register that rotates one column every Period clocks and feeds the collision mux.
// Optional LANE_SHIFT_FILL_EN: shifts take a fill bit instead of rotating (adds LaneShift_Fill_In).
module lane_shift_register #(
  parameter int unsigned               DATAWIDTH_DATA   = 8,
  parameter int unsigned               DATAWIDTH_PERIOD = 24,
  parameter int unsigned               DATAWIDTH_PHASE  = 3,
  parameter logic [DATAWIDTH_DATA-1:0] RESET_PATTERN    = '0
) (
  input  logic                        LaneShift_CLOCK_50,
  input  logic                        LaneShift_RESET_InLow,
  input  logic                        LaneShift_Load_In,
  input  logic [DATAWIDTH_DATA-1:0]   LaneShift_Pattern_Bus_In,
  input  logic                        LaneShift_Enable_In,
  input  logic                        LaneShift_Dir_In,
  input  logic [DATAWIDTH_PERIOD-1:0] LaneShift_Period_Bus_In,
`ifdef LANE_SHIFT_FILL_EN
  input  logic                        LaneShift_Fill_In,
`endif
  output logic [DATAWIDTH_DATA-1:0]   LaneShift_Data_Bus_Out,
  output logic                        LaneShift_Step_Out,
  output logic [DATAWIDTH_PHASE-1:0]  LaneShift_Phase_Bus_Out
);

  localparam logic [DATAWIDTH_PERIOD-1:0] PeriodOne = DATAWIDTH_PERIOD'(1);
  localparam logic [DATAWIDTH_PHASE-1:0]  PhaseOne  = DATAWIDTH_PHASE'(1);

  logic [DATAWIDTH_DATA-1:0]   data_q, data_d;
  logic [DATAWIDTH_PERIOD-1:0] presc_q, presc_d;
  logic [DATAWIDTH_PHASE-1:0]  phase_q, phase_d;
  logic                        step_q, step_d;

  logic                        fill_right, fill_left;
  logic [DATAWIDTH_DATA-1:0]   shifted_right, shifted_left;
  logic                        terminal;

`ifdef LANE_SHIFT_FILL_EN
  assign fill_right = LaneShift_Fill_In;
  assign fill_left  = LaneShift_Fill_In;
`else
  assign fill_right = data_q[0];
  assign fill_left  = data_q[DATAWIDTH_DATA-1];
`endif

  // Right moves toward bit 0 (column 7); left moves toward bit 7 (column 0).
  assign shifted_right = {fill_right, data_q[DATAWIDTH_DATA-1:1]};
  assign shifted_left  = {data_q[DATAWIDTH_DATA-2:0], fill_left};

  // >= so a period lowered below the running count fires next edge instead of wrapping.
  assign terminal = (presc_q >= (LaneShift_Period_Bus_In - PeriodOne));

  always_comb begin
    data_d  = data_q;
    presc_d = presc_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    if (LaneShift_Load_In) begin
      data_d  = LaneShift_Pattern_Bus_In;
      presc_d = '0;
      phase_d = '0;
    end else if (LaneShift_Period_Bus_In == '0) begin
      presc_d = '0;
    end else if (!LaneShift_Enable_In) begin
      presc_d = presc_q;
    end else if (terminal) begin
      presc_d = '0;
      step_d  = 1'b1;
      if (LaneShift_Dir_In) begin
        data_d  = shifted_left;
        phase_d = phase_q - PhaseOne;
      end else begin
        data_d  = shifted_right;
        phase_d = phase_q + PhaseOne;
      end
    end else begin
      presc_d = presc_q + PeriodOne;
    end
  end

  always_ff @(posedge LaneShift_CLOCK_50 or negedge LaneShift_RESET_InLow) begin
    if (!LaneShift_RESET_InLow) begin
      data_q  <= RESET_PATTERN;
      presc_q <= '0;
      phase_q <= '0;
      step_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  assign LaneShift_Data_Bus_Out  = data_q;
  assign LaneShift_Step_Out      = step_q;
  assign LaneShift_Phase_Bus_Out = phase_q;

endmodule

// File: doc/lane_shift_register.md
Name: lane_shift_register

Overview:
- Obstacle-lane row generator that sits directly upstream of the collision 8:1 bit mux.
- Holds the 8-bit occupancy pattern of one game lane and feeds it to the mux data bus.
- Bit 7 is column 0 (leftmost) and bit 0 is column 7.
- Rotates the pattern one column at a programmable rate, so cars and logs move across the screen. The collision mux then samples the frog's column from this bus.

Parameters:
- DATAWIDTH_DATA, 8, lane width in columns; mux data bus width.
- DATAWIDTH_PERIOD, 24, width of the prescaler and the period input.
- DATAWIDTH_PHASE, 3, width of the phase counter; equals log2(DATAWIDTH_DATA).
- RESET_PATTERN, 8'b0000_0000, value of the lane register after reset.

Ports:
- LaneShift_CLOCK_50  in  1  system clock; all state updates on rising edge.
- LaneShift_RESET_InLow  in  1  asynchronous, active-low reset.
- LaneShift_Load_In  in  1  synchronous load strobe for the pattern.
- LaneShift_Pattern_Bus_In  in  DATAWIDTH_DATA  pattern captured on load.
- LaneShift_Enable_In  in  1  1 = run; 0 = pause (prescaler and pattern hold).
- LaneShift_Dir_In  in  1  0 = move right (toward bit 0); 1 = move left (toward bit 7).
- LaneShift_Period_Bus_In  in  DATAWIDTH_PERIOD  clocks per shift; 0 = lane frozen.
- LaneShift_Data_Bus_Out  out  DATAWIDTH_DATA  registered lane pattern; goes to the mux data input.
- LaneShift_Step_Out  out  1  one-cycle pulse in the cycle the new shifted pattern first appears.
- LaneShift_Phase_Bus_Out  out  DATAWIDTH_PHASE  net shift count mod 8.

Behaviour:
- Reset (asynchronous, RESET_InLow = 0):
  - Data_Bus_Out = RESET_PATTERN, Step_Out = 0, Phase = 0, prescaler = 0.
  - Outputs stay in reset state until the first rising edge after reset is released.
- Priority each cycle, highest first: Load > Period==0 > Enable==0 > count.
- Load = 1:
  - Data_Bus_Out <= Pattern_Bus_In; prescaler <= 0; Phase <= 0; Step_Out <= 0.
  - Ignores Enable and Period.
- Period == 0 (no load):
  - Prescaler forced to 0, pattern holds, Step_Out = 0.
- Enable = 0 (no load, Period != 0):
  - Prescaler, pattern and Phase hold; Step_Out = 0.
- Count (Enable = 1, Period != 0):
  - If prescaler >= Period-1 (terminal), shift this edge: prescaler <= 0 and Step_Out <= 1.
  - Otherwise prescaler <= prescaler + 1 and Step_Out <= 0.
  - The >= compare means a Period lowered below the current count causes a shift on the next edge, never a full wrap of the counter.
- Shift right (Dir = 0): rotate right; bit 0 wraps to bit 7; Phase <= Phase + 1 mod 8.
- Shift left (Dir = 1): rotate left; bit 7 wraps to bit 0; Phase <= Phase - 1 mod 8.
- Dir is sampled only on the terminal edge; changing Dir mid-count has no other effect.
- Latency: the pattern changes on the edge that ends cycle Period-1 after the last shift or load. Period = 1 shifts every clock.
- Step_Out is high for exactly one cycle per shift and is coincident with the new Data_Bus_Out value.
- Phase wraps 7 -> 0 (right) and 0 -> 7 (left).
- After 8 shifts in one direction, Data_Bus_Out equals the loaded pattern again.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: LANE_SHIFT_FILL_EN.
- Defined:
  - Adds input port LaneShift_Fill_In (1 bit).
  - Shifts become non-rotating: the vacated end bit takes Fill_In (bit 7 on right shift, bit 0 on left) and the bit shifted out is discarded.
  - Phase still counts as above.
  - Used for lanes that spawn traffic randomly.
- Undefined: port absent; pure rotation as specified.

Test Plan:
1. Reset check: hold RESET_InLow = 0 for 3 clocks with Load = 1 and Pattern = 8'hFF -> Data = 8'h00, Step = 0, Phase = 0 throughout. Release reset -> first load captures 8'hFF.
2. Right rotation: load 8'b1000_0001, Period = 4, Dir = 0, Enable = 1 -> Step pulses every 4 clocks. Data sequence 8'hC0, 8'h60, 8'h30, ... Phase 1, 2, 3. After 8 steps Data = 8'h81, Phase = 0.
3. Left rotation and wrap: load 8'b1000_0000, Period = 1, Dir = 1 -> Data = 8'h01 next clock, then 8'h02. Phase 7, then 6. Step stays high every clock.
4. Pause and freeze: mid-count (prescaler = 2, Period = 5) drop Enable for 10 clocks -> Data and Phase unchanged, no Step. Re-enable -> shift exactly 3 clocks later. Period = 0 -> no shift over 100 clocks.
5. Collisions of events: Load asserted on a terminal-count edge -> loaded pattern wins, no Step, Phase = 0. Lower Period from 10 to 3 when prescaler = 6 -> shift on the next edge. Assert reset mid-count -> outputs clear immediately, without waiting for a clock.
6. With LANE_SHIFT_FILL_EN: load 8'h80, Dir = 0, Fill_In = 0, Period = 1 -> Data 8'h40, 8'h20, ..., 8'h01, then 8'h00 and it stays 8'h00. Then Fill_In = 1 for one shift -> Data 8'h80.
